vend_ctrl: RTL and testbench
============================

Name: vend_ctrl

Overview:
Parametrised vending-machine transaction controller, successor to the fixed-price, fixed-coin purchase logic. Accepts debounced single-cycle pulses from NUM_COIN coin channels, each with its own value, plus buy and cancel keys, and keeps a saturating balance. Runs the vend/refund/timeout sequence with an internal seconds timebase. Outputs balance, change and status to the display/regshow path.

Parameters:
NUM_COIN, 3, number of coin input channels (1..8)
VAL_W, 8, width of each coin value, balance and change
COIN_VALUES, {8'd50,8'd10,8'd5}, packed NUM_COIN*VAL_W values; channel i = bits [i*VAL_W +: VAL_W]
PRICE, 25, product price in coin units (1..2^VAL_W-1)
CLK_PER_SEC, 50_000_000, clk cycles per one-second tick
TIMEOUT_S, 10, idle seconds in COLLECT before auto-refund
HOLD_S, 2, seconds VEND/REFUND result is held for display

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
coin  in  NUM_COIN  one-cycle coin pulses, one bit per channel
buy  in  1  one-cycle purchase request
cancel  in  1  one-cycle cancel/refund request
balance  out  VAL_W  current credited amount
change  out  VAL_W  change/refund amount of last transaction
change_vld  out  1  one-cycle pulse, change valid
dispense  out  1  one-cycle product-release pulse
coin_reject  out  1  one-cycle pulse, coins of this cycle not credited
state_o  out  2  0 IDLE, 1 COLLECT, 2 VEND, 3 REFUND
busy  out  1  high in VEND or REFUND

Behaviour:
- Reset (async, rstn low): state IDLE; balance, change, all pulses 0; sec counter and second counters 0. Reset mid-transaction discards credit, no change_vld.
- All outputs registered; an input sampled at edge N is reflected after edge N (1-cycle latency).
- Coin sum: add COIN_VALUES of every set coin bit that cycle, in VAL_W+3 bit arithmetic. If balance+sum > 2^VAL_W-1, credit nothing, pulse coin_reject. Balance never wraps.
- IDLE: accepted coin -> COLLECT with balance = sum. buy/cancel ignored.
- COLLECT: accepted coin adds to balance and restarts the timeout counter. The timeout counter counts 1 s ticks; at TIMEOUT_S -> REFUND.
- COLLECT buy: checked against registered balance (pre-coin of the same cycle). If balance >= PRICE -> VEND; else ignored (coins that cycle still credited).
- COLLECT cancel: -> REFUND. Cancel has priority over buy and timeout. Coins in the cancel cycle are rejected (coin_reject).
- VEND entry cycle: dispense=1, change=balance-PRICE, change_vld=1, balance=0.
- REFUND entry cycle: change=balance, change_vld=1, balance=0, dispense=0.
- VEND/REFUND hold HOLD_S seconds (tick counter restarted on entry), then IDLE. change is kept until the next change_vld or reset. Coins in VEND/REFUND pulse coin_reject. buy/cancel are ignored.
- 1 s tick: free counter 0..CLK_PER_SEC-1, cleared on every state entry, so hold and timeout durations are exact to ±0 cycles from entry.
- Exact change (balance==PRICE): change=0, change_vld still pulses.

Optional Feature:
Macro VEND_AUTO_EN. Defined: in COLLECT, as soon as the registered balance >= PRICE, the next edge enters VEND without buy. buy is ignored, and cancel in that same cycle still wins. Not defined: vend only on buy as above.

Test Plan:
CLK_PER_SEC=10, TIMEOUT_S=10, HOLD_S=2 for all.
- Reset, coin[1] (10) x3, buy -> balance 10,20,30; dispense+change_vld one cycle, change=5, balance 0, IDLE after 20 cycles.
- coin[0]=5 then buy -> ignored, stays COLLECT with balance 5. Cancel -> REFUND, change=5, change_vld, IDLE 20 cycles later.
- coin[2] (50), coin[2] x4, then coin[2] again: balance 250, then 6th coin -> coin_reject pulse, balance stays 250. Separately coin=3'b111 in one cycle -> +65.
- coin 10, idle 100 cycles -> REFUND at cycle 100, change=10. Coin at cycle 99 restarts the count, no refund.
- Same cycle buy+cancel+coin[1] with balance 30 -> REFUND, change=30, coin_reject=1, no dispense. rstn low mid-VEND hold -> all outputs 0 immediately.
- VEND_AUTO_EN defined: coins 10,10,5 -> VEND on the edge after balance reaches 25, change=0, change_vld=1, no buy needed.

Source files
------------

// File: rtl/vend_ctrl.sv
// ============================================================================
// Module   : vend_ctrl
// Brief    : Parametrised vending transaction controller: coin credit, buy,
//            cancel, timeout auto-refund and timed result hold.
//            Optional macro VEND_AUTO_EN: vend as soon as balance >= PRICE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_ctrl #(
    parameter int                          NUM_COIN    = 3,
    parameter int                          VAL_W       = 8,
    parameter logic [NUM_COIN*VAL_W-1:0]   COIN_VALUES = {8'd50, 8'd10, 8'd5},
    parameter int                          PRICE       = 25,
    parameter int                          CLK_PER_SEC = 50_000_000,
    parameter int                          TIMEOUT_S   = 10,
    parameter int                          HOLD_S      = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NUM_COIN-1:0] coin,
    input  logic                buy,
    input  logic                cancel,
    output logic [VAL_W-1:0]    balance,
    output logic [VAL_W-1:0]    change,
    output logic                change_vld,
    output logic                dispense,
    output logic                coin_reject,
    output logic [1:0]          state_o,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_REFUND  = 2'd3
    } state_t;

    localparam int CNT_W   = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam int SEC_MAX = (TIMEOUT_S > HOLD_S) ? TIMEOUT_S : HOLD_S;
    localparam int SEC_W   = $clog2(SEC_MAX + 1);
    // One bit wider than the coin sum so balance + sum never overflows here.
    localparam int SUM_W   = VAL_W + 4;

    localparam logic [SUM_W-1:0] BAL_MAX   = {4'b0000, {VAL_W{1'b1}}};
    localparam logic [VAL_W-1:0] PRICE_V   = VAL_W'(PRICE);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_PER_SEC - 1);
    localparam logic [SEC_W-1:0] TO_LAST   = SEC_W'(TIMEOUT_S - 1);
    localparam logic [SEC_W-1:0] HOLD_LAST = SEC_W'(HOLD_S - 1);

    state_t             state_q;
    logic [VAL_W-1:0]   balance_q;
    logic [VAL_W-1:0]   change_q;
    logic               change_vld_q;
    logic               dispense_q;
    logic               coin_reject_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SEC_W-1:0]   sec_q;

    logic [SUM_W-1:0]   w_sum;
    logic [SUM_W-1:0]   w_total;
    logic               w_any;
    logic               w_fits;
    logic               w_tick;
    logic               w_can_vend;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_COIN; i++) begin
            if (coin[i]) begin
                w_sum = w_sum + SUM_W'(COIN_VALUES[i*VAL_W +: VAL_W]);
            end
        end
        w_total = {4'b0000, balance_q} + w_sum;
        w_any   = |coin;
        w_fits  = (w_total <= BAL_MAX);
        w_tick  = (cnt_q == CNT_LAST);
`ifdef VEND_AUTO_EN
        w_can_vend = (balance_q >= PRICE_V);
`else
        w_can_vend = buy && (balance_q >= PRICE_V);
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            balance_q     <= '0;
            change_q      <= '0;
            change_vld_q  <= 1'b0;
            dispense_q    <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
            cnt_q         <= '0;
            sec_q         <= '0;
        end else begin
            change_vld_q  <= 1'b0;
            dispense_q    <= 1'b0;
            coin_reject_q <= 1'b0;
            cnt_q         <= w_tick ? '0 : cnt_q + 1'b1;
            if (w_tick) begin
                sec_q <= sec_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    sec_q <= '0;
                    if (w_any) begin
                        if (w_fits) begin
                            state_q   <= S_COLLECT;
                            balance_q <= w_total[VAL_W-1:0];
                        end else begin
                            coin_reject_q <= 1'b1;
                        end
                    end
                end

                S_COLLECT: begin
                    if (cancel || (!w_can_vend && !(w_any && w_fits)
                                   && w_tick && (sec_q == TO_LAST))) begin
                        state_q       <= S_REFUND;
                        change_q      <= balance_q;
                        change_vld_q  <= 1'b1;
                        balance_q     <= '0;
                        busy_q        <= 1'b1;
                        cnt_q         <= '0;
                        sec_q         <= '0;
                        coin_reject_q <= w_any;
                    end else if (w_can_vend) begin
                        state_q       <= S_VEND;
                        dispense_q    <= 1'b1;
                        change_q      <= balance_q - PRICE_V;
                        change_vld_q  <= 1'b1;
                        balance_q     <= '0;
                        busy_q        <= 1'b1;
                        cnt_q         <= '0;
                        sec_q         <= '0;
                        coin_reject_q <= w_any;
                    end else if (w_any && w_fits) begin
                        // Accepted credit restarts the idle timeout.
                        balance_q <= w_total[VAL_W-1:0];
                        cnt_q     <= '0;
                        sec_q     <= '0;
                    end else begin
                        coin_reject_q <= w_any;
                    end
                end

                default: begin
                    coin_reject_q <= w_any;
                    if (w_tick && (sec_q == HOLD_LAST)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        sec_q   <= '0;
                    end
                end
            endcase
        end
    end

    assign balance     = balance_q;
    assign change      = change_q;
    assign change_vld  = change_vld_q;
    assign dispense    = dispense_q;
    assign coin_reject = coin_reject_q;
    assign state_o     = state_q;
    assign busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_vend_ctrl.sv
// ============================================================================
// Module   : tb_vend_ctrl
// Brief    : Scoreboard bench for vend_ctrl with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vend_ctrl;

    localparam int PRICE  = 25;
    localparam int CPS    = 10;
    localparam int TO_S   = 10;
    localparam int HOLD_S = 2;

    int VALS [3] = '{5, 10, 50};

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] coin = 3'b000;
    logic       buy = 1'b0;
    logic       cancel = 1'b0;
    logic [7:0] balance, change;
    logic       change_vld, dispense, coin_reject, busy;
    logic [1:0] state_o;

    vend_ctrl #(
        .NUM_COIN    (3),
        .VAL_W       (8),
        .COIN_VALUES ({8'd50, 8'd10, 8'd5}),
        .PRICE       (PRICE),
        .CLK_PER_SEC (CPS),
        .TIMEOUT_S   (TO_S),
        .HOLD_S      (HOLD_S)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .coin        (coin),
        .buy         (buy),
        .cancel      (cancel),
        .balance     (balance),
        .change      (change),
        .change_vld  (change_vld),
        .dispense    (dispense),
        .coin_reject (coin_reject),
        .state_o     (state_o),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic [7:0] bal;
        logic [7:0] chg;
        logic       vld;
        logic       disp;
        logic       rej;
        logic       busy;
    } exp_t;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;
    bit   mon_en     = 1'b0;

    // Transaction-level model: state as a small integer, time as elapsed cycles.
    int m_st, m_bal, m_chg, m_t;
    bit m_vld, m_disp, m_rej;

    function automatic void model_reset();
        m_st = 0; m_bal = 0; m_chg = 0; m_t = 0;
        m_vld = 0; m_disp = 0; m_rej = 0;
    endfunction

    function automatic void model_step(input logic [2:0] c, input logic b, input logic x);
        int sum;
        bit any, fits, vend_ok;
        sum = 0;
        for (int i = 0; i < 3; i++) if (c[i]) sum += VALS[i];
        any  = (c != 3'b000);
        fits = (m_bal + sum) <= 255;
        m_vld = 0; m_disp = 0; m_rej = 0;
`ifdef VEND_AUTO_EN
        vend_ok = (m_bal >= PRICE) || (b && 1'b0);
`else
        vend_ok = b && (m_bal >= PRICE);
`endif
        if (m_st == 0) begin
            if (any) begin
                if (fits) begin m_bal = sum; m_st = 1; m_t = 0; end
                else m_rej = 1;
            end
        end else if (m_st == 1) begin
            if (x) begin
                m_chg = m_bal; m_vld = 1; m_bal = 0; m_st = 3; m_t = 0; m_rej = any;
            end else if (vend_ok) begin
                m_chg = m_bal - PRICE; m_vld = 1; m_disp = 1; m_bal = 0;
                m_st = 2; m_t = 0; m_rej = any;
            end else if (any && fits) begin
                m_bal += sum; m_t = 0;
            end else begin
                m_rej = any;
                m_t++;
                if (m_t == TO_S * CPS) begin
                    m_chg = m_bal; m_vld = 1; m_bal = 0; m_st = 3; m_t = 0;
                end
            end
        end else begin
            m_rej = any;
            m_t++;
            if (m_t == HOLD_S * CPS) begin m_st = 0; m_t = 0; end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.st   = 2'(m_st);
        e.bal  = 8'(m_bal);
        e.chg  = 8'(m_chg);
        e.vld  = m_vld;
        e.disp = m_disp;
        e.rej  = m_rej;
        e.busy = (m_st >= 2);
        return e;
    endfunction

    task automatic cycle(input logic [2:0] c, input logic b, input logic x);
        @(negedge clk);
        rstn = 1'b1; coin = c; buy = b; cancel = x;
        model_step(c, b, x);
        sbq.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(3'b000, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; coin = 3'b000; buy = 1'b0; cancel = 1'b0;
        model_reset();
        #1;
        compared++;
        if ({state_o, balance, change, change_vld, dispense, coin_reject, busy} != 22'd0) begin
            mismatched++;
            $display("FAIL async_reset: got st=%0d bal=%0d chg=%0d vld=%0b disp=%0b rej=%0b busy=%0b, want all 0",
                     state_o, balance, change, change_vld, dispense, coin_reject, busy);
        end
        sbq.push_back('0);
        mon_en = 1'b1;
        @(negedge clk);
        sbq.push_back('0);
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            exp_t e, a;
            a = {state_o, balance, change, change_vld, dispense, coin_reject, busy};
            compared++;
            if (sbq.size() == 0) begin
                mismatched++;
                $display("FAIL scoreboard_empty at %0t: got st=%0d bal=%0d, want a queued entry", $time, state_o, balance);
            end else begin
                e = sbq.pop_front();
                if (a !== e) begin
                    mismatched++;
                    $display("FAIL outputs at %0t: got st=%0d bal=%0d chg=%0d vld=%0b disp=%0b rej=%0b busy=%0b, want st=%0d bal=%0d chg=%0d vld=%0b disp=%0b rej=%0b busy=%0b",
                             $time, a.st, a.bal, a.chg, a.vld, a.disp, a.rej, a.busy,
                             e.st, e.bal, e.chg, e.vld, e.disp, e.rej, e.busy);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of stimulus, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dens;
        model_reset();
        do_reset();

        // Purchase with 5 change
        repeat (3) cycle(3'b010, 1'b0, 1'b0);
        cycle(3'b000, 1'b1, 1'b0);
        idle(22);

        // Insufficient buy ignored, then cancel
        cycle(3'b001, 1'b0, 1'b0);
        cycle(3'b000, 1'b1, 1'b0);
        cycle(3'b000, 1'b0, 1'b1);
        idle(22);

        // Saturation at 250 and multi-coin cycle
        repeat (5) cycle(3'b100, 1'b0, 1'b0);
        cycle(3'b100, 1'b0, 1'b0);
        cycle(3'b111, 1'b0, 1'b0);
        cycle(3'b000, 1'b0, 1'b1);
        idle(22);
        cycle(3'b111, 1'b0, 1'b0);
        cycle(3'b000, 1'b0, 1'b1);
        idle(22);

        // Timeout refund, then coin at cycle 99 restarting the count
        cycle(3'b010, 1'b0, 1'b0);
        idle(125);
        cycle(3'b010, 1'b0, 1'b0);
        idle(98);
        cycle(3'b010, 1'b0, 1'b0);
        idle(50);
        cycle(3'b000, 1'b0, 1'b1);
        idle(22);

        // buy + cancel + coin together
        repeat (3) cycle(3'b010, 1'b0, 1'b0);
        cycle(3'b010, 1'b1, 1'b1);
        idle(22);

        // Exact-change path (auto-vend when enabled)
        cycle(3'b010, 1'b0, 1'b0);
        cycle(3'b010, 1'b0, 1'b0);
        cycle(3'b001, 1'b0, 1'b0);
        cycle(3'b000, 1'b1, 1'b0);
        idle(22);

        // Reset during vend hold
        repeat (3) cycle(3'b010, 1'b0, 1'b0);
        cycle(3'b000, 1'b1, 1'b0);
        idle(5);
        do_reset();
        idle(3);

        // Randomised phases with varying coin density
        for (int ph = 0; ph < 6; ph++) begin
            dens = (ph % 3 == 0) ? 30 : ((ph % 3 == 1) ? 6 : 1);
            for (int i = 0; i < 600; i++) begin
                logic [2:0] c;
                logic b, x;
                c = ($urandom_range(0, 99) < dens) ? 3'($urandom_range(1, 7)) : 3'b000;
                b = ($urandom_range(0, 99) < 8);
                x = ($urandom_range(0, 99) < 2);
                if ($urandom_range(0, 999) == 0) do_reset();
                else cycle(c, b, x);
            end
        end
        idle(3);

        @(posedge clk);
        #2;
        mon_en = 1'b0;
        compared++;
        if (sbq.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
